// File: rtl/uart_receiver.sv
// uart_receiver: oversampled UART receiver feeding a first-word-fall-through RX FIFO
module uart_receiver #(
  parameter int RX_FIFO_DEPTH = 32,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  input  logic       ov_baud_rt_i,
  input  logic [1:0] data_width_i,
  input  logic [1:0] stop_bits_number_i,
  input  logic       config_req_i,
  output logic       req_done_o,
  input  logic       rx_fifo_read_i,
  output logic [7:0] data_rx_o,
  output logic       rx_fifo_empty_o,
  output logic       rx_fifo_full_o,
  output logic       rx_done_o,
  output logic       frame_error_o,
  output logic       overrun_error_o
);
  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] MID_TICK = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] END_TICK = CW'(OVERSAMPLE - 1);
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_CFG} state_t;
  state_t state_q, state_d;
  logic rx_meta, rx_s;
  logic [CW-1:0] tick_cnt;
  logic [2:0] bit_cnt;
  logic stop_cnt, ferr;
  logic [7:0] shift_q;
  logic [1:0] dw_q, sb_q;
  logic mid_tick, end_tick, bit_last, stop_last, frame_done;
  logic [7:0] mem [RX_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CNTW-1:0] count;
  logic wr_en, rd_en;
  assign mid_tick = ov_baud_rt_i && tick_cnt == MID_TICK;
  assign end_tick = ov_baud_rt_i && tick_cnt == END_TICK;
  assign bit_last = bit_cnt == 3'd4 + {1'b0, dw_q};
  assign stop_last = stop_cnt == (|sb_q);
  assign frame_done = state_q == RX_STOP && end_tick && stop_last;
  // Two-flop synchronizer for the asynchronous serial line, idling high
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s <= rx_meta;
    end
  end
  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= RX_IDLE;
    else state_q <= state_d;
  end
  // Next-state and status outputs; config requests wait for frame boundaries
  always_comb begin
    state_d = state_q;
    rx_done_o = frame_done;
    frame_error_o = frame_done && (ferr || !rx_s);
    overrun_error_o = frame_done && rx_fifo_full_o && !rx_fifo_read_i;
    req_done_o = state_q == RX_CFG;
    case (state_q)
      RX_IDLE:  state_d = config_req_i ? RX_CFG : (rx_s ? RX_IDLE : RX_START);
      RX_START: state_d = mid_tick ? (rx_s ? RX_IDLE : RX_DATA) : RX_START;
      RX_DATA:  state_d = (end_tick && bit_last) ? RX_STOP : RX_DATA;
      RX_STOP:  state_d = frame_done ? (config_req_i ? RX_CFG : RX_IDLE) : RX_STOP;
      RX_CFG:   state_d = config_req_i ? RX_CFG : RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end
  // Tick counter, frame format latch and deserialiser
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tick_cnt <= '0;
      bit_cnt <= '0;
      stop_cnt <= 1'b0;
      ferr <= 1'b0;
      shift_q <= '0;
      dw_q <= '0;
      sb_q <= '0;
    end else begin
      tick_cnt <= (state_d != state_q) ? '0 : tick_cnt + CW'(ov_baud_rt_i);
      if (state_q == RX_START && mid_tick && !rx_s) begin
        dw_q <= data_width_i;
        sb_q <= stop_bits_number_i;
        bit_cnt <= '0;
        stop_cnt <= 1'b0;
        ferr <= 1'b0;
        shift_q <= '0;
      end
      if (state_q == RX_DATA && end_tick) begin
        shift_q[bit_cnt] <= rx_s;
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (state_q == RX_STOP && end_tick) begin
        ferr <= ferr | ~rx_s;
        stop_cnt <= 1'b1;
      end
    end
  end
  assign wr_en = frame_done && (!rx_fifo_full_o || rx_fifo_read_i);
  assign rd_en = rx_fifo_read_i && !rx_fifo_empty_o;
  assign rx_fifo_empty_o = count == '0;
  assign rx_fifo_full_o = count == CNTW'(RX_FIFO_DEPTH);
  assign data_rx_o = rx_fifo_empty_o ? 8'h00 : mem[rd_ptr];
  // FIFO pointers and occupancy; reset flushes immediately
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNTW'(wr_en) - CNTW'(rd_en);
    end
  end
  // FIFO storage, no reset needed since empty masks the head
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= shift_q;
  end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed self-checking bench for uart_receiver
module tb_uart_receiver;
  localparam int BIT = 64;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic rx_i = 1'b1;
  logic ov_baud_rt_i = 1'b0;
  logic [1:0] data_width_i = 2'b11;
  logic [1:0] stop_bits_number_i = 2'b00;
  logic config_req_i = 1'b0;
  logic rx_fifo_read_i = 1'b0;
  logic req_done_o, rx_fifo_empty_o, rx_fifo_full_o, rx_done_o, frame_error_o, overrun_error_o;
  logic [7:0] data_rx_o;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int lone_ferr = 0;
  int ovr_cnt = 0;
  int d0, f0, o0;
  uart_receiver dut (
    .clk_i(clk), .rst_i(rst_i), .rx_i(rx_i), .ov_baud_rt_i(ov_baud_rt_i),
    .data_width_i(data_width_i), .stop_bits_number_i(stop_bits_number_i),
    .config_req_i(config_req_i), .req_done_o(req_done_o), .rx_fifo_read_i(rx_fifo_read_i),
    .data_rx_o(data_rx_o), .rx_fifo_empty_o(rx_fifo_empty_o), .rx_fifo_full_o(rx_fifo_full_o),
    .rx_done_o(rx_done_o), .frame_error_o(frame_error_o), .overrun_error_o(overrun_error_o)
  );
  always #5 clk = ~clk;
  initial begin
    int div = 0;
    forever begin
      @(negedge clk);
      div = (div + 1) % 4;
      ov_baud_rt_i = div == 0;
    end
  end
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rx_done_o) done_cnt++;
      if (frame_error_o) ferr_cnt++;
      if (frame_error_o && !rx_done_o) lone_ferr++;
      if (overrun_error_o) ovr_cnt++;
    end
  end
  task automatic send_frame(input logic [7:0] d, input int nbits, input int nstop, input bit stop_low);
    @(negedge clk);
    rx_i = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      rx_i = d[i];
      repeat (BIT) @(negedge clk);
    end
    for (int i = 0; i < nstop; i++) begin
      rx_i = !(stop_low && i == 0);
      repeat (44) @(negedge clk);
      rx_i = 1'b1;
      repeat (BIT - 44) @(negedge clk);
    end
    rx_i = 1'b1;
    repeat (16) @(negedge clk);
  endtask
  task automatic pop();
    @(negedge clk);
    rx_fifo_read_i = 1'b1;
    @(negedge clk);
    rx_fifo_read_i = 1'b0;
    #1;
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({req_done_o, rx_done_o, frame_error_o, overrun_error_o, rx_fifo_empty_o, rx_fifo_full_o, data_rx_o} !== 14'b0000_1_0_00000000) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b done=%b fe=%b ov=%b empty=%b full=%b data=%h, expected 0 0 0 0 1 0 00",
               req_done_o, rx_done_o, frame_error_o, overrun_error_o, rx_fifo_empty_o, rx_fifo_full_o, data_rx_o);
    end
    rst_i = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (rx_fifo_empty_o !== 1'b1 || req_done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got empty=%b req=%b expected 1 0", rx_fifo_empty_o, req_done_o);
    end
  endtask
  task automatic test_8n1();
    data_width_i = 2'b11;
    stop_bits_number_i = 2'b00;
    d0 = done_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'hA5, 8, 1, 1'b0);
    #1;
    checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL 8n1_done: got %0d pulses expected 1", done_cnt - d0); end
    checks++;
    if (data_rx_o !== 8'hA5) begin errors++; $display("FAIL 8n1_data: got %h expected a5", data_rx_o); end
    checks++;
    if (rx_fifo_empty_o !== 1'b0) begin errors++; $display("FAIL 8n1_empty: got %b expected 0", rx_fifo_empty_o); end
    checks++;
    if (ferr_cnt - f0 !== 0 || ovr_cnt - o0 !== 0) begin
      errors++;
      $display("FAIL 8n1_errors: got fe=%0d ov=%0d expected 0 0", ferr_cnt - f0, ovr_cnt - o0);
    end
    pop();
    checks++;
    if (rx_fifo_empty_o !== 1'b1 || data_rx_o !== 8'h00) begin
      errors++;
      $display("FAIL 8n1_pop: got empty=%b data=%h expected 1 00", rx_fifo_empty_o, data_rx_o);
    end
  endtask
  task automatic test_5n2();
    data_width_i = 2'b00;
    stop_bits_number_i = 2'b10;
    d0 = done_cnt;
    send_frame(8'h15, 5, 1, 1'b0);
    checks++;
    if (done_cnt - d0 !== 0) begin errors++; $display("FAIL 5n2_early_done: got %0d pulses expected 0", done_cnt - d0); end
    repeat (BIT) @(negedge clk);
    #1;
    checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL 5n2_done: got %0d pulses expected 1", done_cnt - d0); end
    checks++;
    if (data_rx_o !== 8'h15) begin errors++; $display("FAIL 5n2_data: got %h expected 15", data_rx_o); end
    pop();
    data_width_i = 2'b11;
    stop_bits_number_i = 2'b00;
  endtask
  task automatic test_glitch();
    d0 = done_cnt;
    @(negedge clk);
    rx_i = 1'b0;
    repeat (16) @(negedge clk);
    rx_i = 1'b1;
    repeat (100) @(negedge clk);
    #1;
    checks++;
    if (done_cnt - d0 !== 0 || rx_fifo_empty_o !== 1'b1) begin
      errors++;
      $display("FAIL glitch_ignored: got done=%0d empty=%b expected 0 1", done_cnt - d0, rx_fifo_empty_o);
    end
    send_frame(8'h3C, 8, 1, 1'b0);
    #1;
    checks++;
    if (done_cnt - d0 !== 1 || data_rx_o !== 8'h3C) begin
      errors++;
      $display("FAIL glitch_next_frame: got done=%0d data=%h expected 1 3c", done_cnt - d0, data_rx_o);
    end
    pop();
  endtask
  task automatic test_frame_error();
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 8, 1, 1'b1);
    repeat (BIT) @(negedge clk);
    #1;
    checks++;
    if (done_cnt - d0 !== 1 || ferr_cnt - f0 !== 1 || lone_ferr !== 0) begin
      errors++;
      $display("FAIL ferr_pulse: got done=%0d fe=%0d lone=%0d expected 1 1 0", done_cnt - d0, ferr_cnt - f0, lone_ferr);
    end
    checks++;
    if (data_rx_o !== 8'h3C) begin errors++; $display("FAIL ferr_stored: got %h expected 3c", data_rx_o); end
    send_frame(8'h5A, 8, 1, 1'b0);
    #1;
    checks++;
    if (done_cnt - d0 !== 2 || ferr_cnt - f0 !== 1) begin
      errors++;
      $display("FAIL ferr_next_clean: got done=%0d fe=%0d expected 2 1", done_cnt - d0, ferr_cnt - f0);
    end
    pop();
    checks++;
    if (data_rx_o !== 8'h5A) begin errors++; $display("FAIL ferr_second_head: got %h expected 5a", data_rx_o); end
    pop();
  endtask
  task automatic test_overrun();
    for (int i = 0; i < 32; i++) send_frame(8'(i), 8, 1, 1'b0);
    #1;
    checks++;
    if (rx_fifo_full_o !== 1'b1) begin errors++; $display("FAIL ovr_full: got %b expected 1", rx_fifo_full_o); end
    o0 = ovr_cnt;
    send_frame(8'h20, 8, 1, 1'b0);
    #1;
    checks++;
    if (ovr_cnt - o0 !== 1) begin errors++; $display("FAIL ovr_pulse: got %0d expected 1", ovr_cnt - o0); end
    checks++;
    if (data_rx_o !== 8'h00 || rx_fifo_full_o !== 1'b1) begin
      errors++;
      $display("FAIL ovr_contents: got data=%h full=%b expected 00 1", data_rx_o, rx_fifo_full_o);
    end
    o0 = ovr_cnt;
    fork
      send_frame(8'h21, 8, 1, 1'b0);
      begin
        bit seen = 1'b0;
        for (int k = 0; k < 2000 && !seen; k++) begin
          @(negedge clk);
          #2;
          seen = rx_done_o;
        end
        checks++;
        if (!seen) begin
          errors++;
          $display("FAIL ovr_rw_timeout: got no rx_done expected one within 2000 cycles");
        end else begin
          rx_fifo_read_i = 1'b1;
          @(posedge clk);
          #1;
          rx_fifo_read_i = 1'b0;
        end
      end
    join
    #1;
    checks++;
    if (ovr_cnt - o0 !== 0 || rx_fifo_full_o !== 1'b1 || data_rx_o !== 8'h01) begin
      errors++;
      $display("FAIL ovr_read_write: got ov=%0d full=%b data=%h expected 0 1 01", ovr_cnt - o0, rx_fifo_full_o, data_rx_o);
    end
    for (int i = 0; i < 32; i++) begin
      logic [7:0] exp;
      exp = (i < 31) ? 8'(i + 1) : 8'h21;
      checks++;
      if (data_rx_o !== exp) begin errors++; $display("FAIL ovr_drain[%0d]: got %h expected %h", i, data_rx_o, exp); end
      pop();
    end
    checks++;
    if (rx_fifo_empty_o !== 1'b1) begin errors++; $display("FAIL ovr_drained: got empty=%b expected 1", rx_fifo_empty_o); end
    pop();
    send_frame(8'h77, 8, 1, 1'b0);
    #1;
    checks++;
    if (data_rx_o !== 8'h77) begin errors++; $display("FAIL empty_read_ignored: got %h expected 77", data_rx_o); end
    pop();
  endtask
  task automatic test_config();
    d0 = done_cnt;
    fork
      send_frame(8'h81, 8, 1, 1'b0);
      begin
        repeat (200) @(negedge clk);
        config_req_i = 1'b1;
        repeat (200) @(negedge clk);
        #1;
        checks++;
        if (req_done_o !== 1'b0) begin errors++; $display("FAIL cfg_midframe: got %b expected 0", req_done_o); end
      end
    join
    #1;
    checks++;
    if (req_done_o !== 1'b1 || done_cnt - d0 !== 1 || data_rx_o !== 8'h81) begin
      errors++;
      $display("FAIL cfg_after_frame: got req=%b done=%0d data=%h expected 1 1 81", req_done_o, done_cnt - d0, data_rx_o);
    end
    send_frame(8'h0F, 8, 1, 1'b0);
    #1;
    checks++;
    if (done_cnt - d0 !== 1 || req_done_o !== 1'b1) begin
      errors++;
      $display("FAIL cfg_rx_ignored: got done=%0d req=%b expected 1 1", done_cnt - d0, req_done_o);
    end
    @(negedge clk);
    config_req_i = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (req_done_o !== 1'b0) begin errors++; $display("FAIL cfg_release: got %b expected 0", req_done_o); end
    pop();
    checks++;
    if (rx_fifo_empty_o !== 1'b1) begin errors++; $display("FAIL cfg_only_one: got empty=%b expected 1", rx_fifo_empty_o); end
  endtask
  task automatic test_reset_midframe();
    send_frame(8'h42, 8, 1, 1'b0);
    d0 = done_cnt;
    fork
      send_frame(8'hF0, 8, 1, 1'b0);
      begin
        repeat (200) @(negedge clk);
        rst_i = 1'b1;
        #1;
        checks++;
        if ({req_done_o, rx_done_o, frame_error_o, overrun_error_o, rx_fifo_empty_o, rx_fifo_full_o, data_rx_o} !== 14'b0000_1_0_00000000) begin
          errors++;
          $display("FAIL rst_mid_outputs: got req=%b done=%b fe=%b ov=%b empty=%b full=%b data=%h, expected 0 0 0 0 1 0 00",
                   req_done_o, rx_done_o, frame_error_o, overrun_error_o, rx_fifo_empty_o, rx_fifo_full_o, data_rx_o);
        end
        repeat (150) @(negedge clk);
        rst_i = 1'b0;
      end
    join
    repeat (BIT) @(negedge clk);
    #1;
    checks++;
    if (done_cnt - d0 !== 0 || rx_fifo_empty_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_discard: got done=%0d empty=%b expected 0 1", done_cnt - d0, rx_fifo_empty_o);
    end
    send_frame(8'h99, 8, 1, 1'b0);
    #1;
    checks++;
    if (data_rx_o !== 8'h99 || done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL rst_mid_recover: got data=%h done=%0d expected 99 1", data_rx_o, done_cnt - d0);
    end
  endtask
  initial begin
    test_reset();
    test_8n1();
    test_5n2();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_config();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
